// File: rtl/mux_arbiter_2to1_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arbiter_2to1_pkg
//  Purpose  : Shared definitions for the 2:1 mux round-robin arbiter.
//             Holds the FSM state encoding and the default parameter values.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mux_arbiter_2to1_pkg;

    // Arbiter FSM encoding. The grant states are one-hot so that a grant
    // decode is a single bit.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10
    } state_t;

    localparam int HOLD_MAX_DEFAULT = 8;
    localparam int CNT_W_DEFAULT    = 4;

endpackage
`default_nettype wire

// File: rtl/mux_arbiter_2to1_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arbiter_2to1_if
//  Purpose  : Request/grant handshake bundle between the two requesters and
//             the arbiter, plus the mux select it drives.
//  Signals  : req0, req1          - level requests from requester 0 / 1
//             gnt0, gnt1          - registered one-hot grants
//             sel                 - registered MUX_2to1 select (0=In0, 1=In1)
//             busy                - a grant is active
//             preempt             - one-cycle pulse on a hold-limit handover
//  Modports : master - requester side (drives requests)
//             slave  - arbiter side (drives grants and select)
//  Revision : 1.0 - initial release
// ============================================================================
interface mux_arbiter_2to1_if;

    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic sel;
    logic busy;
    logic preempt;

    modport master (
        output req0,
        output req1,
        input  gnt0,
        input  gnt1,
        input  sel,
        input  busy,
        input  preempt
    );

    modport slave (
        input  req0,
        input  req1,
        output gnt0,
        output gnt1,
        output sel,
        output busy,
        output preempt
    );

endinterface
`default_nettype wire

// File: rtl/mux_arbiter_2to1_hold_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mux_hold_counter
//  Purpose  : Saturating hold counter for the arbiter. Counts cycles a grant
//             has been held and flags when the hold limit has been reached.
//  Ports    : clk    - system clock
//             rst_n  - synchronous active-low reset
//             clear  - restart count at 0 (grant entry)
//             enable - advance count by one (grant held)
//             expire - registered flag, high when count == HOLD_MAX-1
//  Revision : 1.0 - initial release
// ============================================================================
module mux_hold_counter #(
    parameter int CNT_W    = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(HOLD_MAX - 1);
    // With HOLD_MAX=1 the limit is already reached at count 0.
    localparam logic             c_exp_zero = (HOLD_MAX == 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_expire;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_expire <= c_exp_zero;
        end else if (clear) begin
            r_cnt    <= '0;
            r_expire <= c_exp_zero;
        end else if (enable && (r_cnt != c_cnt_max)) begin
            // Flag is computed from the next count so it lines up with r_cnt.
            r_cnt    <= w_cnt_inc;
            r_expire <= (w_cnt_inc == c_cnt_max);
        end
    end

    assign expire = r_expire;

endmodule
`default_nettype wire

// File: rtl/mux_arbiter_2to1.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arbiter_2to1
//  Purpose  : Round-robin arbiter sharing one MUX_2to1 between two requesters.
//             Issues registered one-hot grants, drives the mux select and
//             forces a handover after HOLD_MAX cycles under contention.
//  Ports    : clk   - system clock
//             rst_n - synchronous active-low reset
//             bus   - handshake bundle (slave modport): req0/req1 in,
//                     gnt0/gnt1/sel/busy/preempt out (all registered)
//  Revision : 1.0 - initial release
// ============================================================================
module mux_arbiter_2to1
    import mux_arbiter_2to1_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_arbiter_2to1_if.slave   bus
);

    state_t r_state;
    state_t w_next;
    logic   w_preempt;
    logic   w_clear;
    logic   w_enable;
    logic   w_expire;

    logic   r_last;      // side served most recently (1 after reset => req0 wins first tie)
    logic   r_gnt0;
    logic   r_gnt1;
    logic   r_sel;
    logic   r_busy;
    logic   r_preempt;

    mux_hold_counter #(
        .CNT_W    (CNT_W),
        .HOLD_MAX (HOLD_MAX)
    ) u_hold_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_clear),
        .enable (w_enable),
        .expire (w_expire)
    );

    // Next-state logic. A voluntary release takes priority over the hold
    // limit, so the waiting side is granted without a dead IDLE cycle.
    always_comb begin
        w_next    = r_state;
        w_preempt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req0 && bus.req1)
                    w_next = r_last ? ST_G0 : ST_G1;
                else if (bus.req0)
                    w_next = ST_G0;
                else if (bus.req1)
                    w_next = ST_G1;
            end
            ST_G0: begin
                if (!bus.req0 && bus.req1)
                    w_next = ST_G1;
                else if (!bus.req0)
                    w_next = ST_IDLE;
                else if (bus.req1 && w_expire) begin
                    w_next    = ST_G1;
                    w_preempt = 1'b1;
                end
            end
            ST_G1: begin
                if (!bus.req1 && bus.req0)
                    w_next = ST_G0;
                else if (!bus.req1)
                    w_next = ST_IDLE;
                else if (bus.req0 && w_expire) begin
                    w_next    = ST_G0;
                    w_preempt = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase

        // Counter restarts on every grant entry and advances while held.
        w_clear  = ((w_next == ST_G0) && (r_state != ST_G0)) ||
                   ((w_next == ST_G1) && (r_state != ST_G1));
        w_enable = (r_state != ST_IDLE) && (w_next == r_state);
    end

    // State and output registers. Outputs are derived from w_next so they
    // change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_sel     <= 1'b0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
            r_last    <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_gnt0    <= (w_next == ST_G0);
            r_gnt1    <= (w_next == ST_G1);
            r_busy    <= (w_next != ST_IDLE);
            r_preempt <= w_preempt;
            // Sel and Last hold through IDLE so the mux output stays stable.
            if (w_next == ST_G0) begin
                r_sel  <= 1'b0;
                r_last <= 1'b0;
            end else if (w_next == ST_G1) begin
                r_sel  <= 1'b1;
                r_last <= 1'b1;
            end
        end
    end

    assign bus.gnt0    = r_gnt0;
    assign bus.gnt1    = r_gnt1;
    assign bus.sel     = r_sel;
    assign bus.busy    = r_busy;
    assign bus.preempt = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter_2to1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_arbiter_2to1
//  Purpose  : Directed self-checking bench for mux_arbiter_2to1. One instance
//             with HOLD_MAX=4 and one with HOLD_MAX=1 (strict alternation).
//             Observed vector order: {gnt0, gnt1, sel, busy, preempt}.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_arbiter_2to1;

    logic clk;
    logic rst_n;

    int errors = 0;
    int checks = 0;

    mux_arbiter_2to1_if bus4 ();
    mux_arbiter_2to1_if bus1 ();

    logic [4:0] obs4;
    logic [4:0] obs1;
    assign obs4 = {bus4.gnt0, bus4.gnt1, bus4.sel, bus4.busy, bus4.preempt};
    assign obs1 = {bus1.gnt0, bus1.gnt1, bus1.sel, bus1.busy, bus1.preempt};

    mux_arbiter_2to1 #(
        .HOLD_MAX (4),
        .CNT_W    (4)
    ) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    mux_arbiter_2to1 #(
        .HOLD_MAX (1),
        .CNT_W    (4)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        bus4.req0 = 1'b1;
        bus4.req1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs4 !== 5'b00000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs4, 5'b00000);
            end
            checks++;
            if (obs1 !== 5'b00000) begin
                errors++;
                $display("FAIL reset_hold_h1[%0d]: got %b expected %b", i, obs1, 5'b00000);
            end
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs4 !== 5'b10010) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", obs4, 5'b10010);
        end
        bus4.req0 = 1'b0;
        bus4.req1 = 1'b0;
        tick();
        checks++;
        if (obs4 !== 5'b00000) begin
            errors++;
            $display("FAIL reset_idle: got %b expected %b", obs4, 5'b00000);
        end
    endtask

    task automatic test_single;
        bus4.req1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs4 !== 5'b01110) begin
                errors++;
                $display("FAIL single_grant[%0d]: got %b expected %b", i, obs4, 5'b01110);
            end
        end
        bus4.req1 = 1'b0;
        tick();
        checks++;
        if (obs4 !== 5'b00100) begin
            errors++;
            $display("FAIL single_release_sel_hold: got %b expected %b", obs4, 5'b00100);
        end
    endtask

    task automatic test_contention;
        logic [4:0] exp;
        logic       g0;
        bus4.req0 = 1'b1;
        bus4.req1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            g0  = (((i / 4) % 2) == 0);
            exp = {g0, ~g0, ~g0, 1'b1, ((i % 4) == 0) && (i != 0)};
            checks++;
            if (obs4 !== exp) begin
                errors++;
                $display("FAIL contention[%0d]: got %b expected %b", i, obs4, exp);
            end
        end
        bus4.req0 = 1'b0;
        bus4.req1 = 1'b0;
        tick();
        checks++;
        if (obs4 !== 5'b00100) begin
            errors++;
            $display("FAIL contention_idle: got %b expected %b", obs4, 5'b00100);
        end
    endtask

    task automatic test_release_handover;
        bus4.req0 = 1'b1;
        tick();
        checks++;
        if (obs4 !== 5'b10010) begin
            errors++;
            $display("FAIL handover_g0: got %b expected %b", obs4, 5'b10010);
        end
        bus4.req1 = 1'b1;
        tick();
        checks++;
        if (obs4 !== 5'b10010) begin
            errors++;
            $display("FAIL handover_wait: got %b expected %b", obs4, 5'b10010);
        end
        bus4.req0 = 1'b0;
        tick();
        checks++;
        if (obs4 !== 5'b01110) begin
            errors++;
            $display("FAIL handover_direct: got %b expected %b", obs4, 5'b01110);
        end
        bus4.req1 = 1'b0;
        tick();
        checks++;
        if (obs4 !== 5'b00100) begin
            errors++;
            $display("FAIL handover_idle: got %b expected %b", obs4, 5'b00100);
        end
    endtask

    task automatic test_tie;
        // Requester 1 was served last -> tie goes to requester 0.
        bus4.req0 = 1'b1;
        bus4.req1 = 1'b1;
        tick();
        checks++;
        if (obs4 !== 5'b10010) begin
            errors++;
            $display("FAIL tie_after_r1: got %b expected %b", obs4, 5'b10010);
        end
        bus4.req0 = 1'b0;
        bus4.req1 = 1'b0;
        tick();
        checks++;
        if (obs4 !== 5'b00000) begin
            errors++;
            $display("FAIL tie_idle0: got %b expected %b", obs4, 5'b00000);
        end
        // Requester 0 was served last -> tie goes to requester 1.
        bus4.req0 = 1'b1;
        bus4.req1 = 1'b1;
        tick();
        checks++;
        if (obs4 !== 5'b01110) begin
            errors++;
            $display("FAIL tie_after_r0: got %b expected %b", obs4, 5'b01110);
        end
        bus4.req0 = 1'b0;
        bus4.req1 = 1'b0;
        tick();
        checks++;
        if (obs4 !== 5'b00100) begin
            errors++;
            $display("FAIL tie_idle1: got %b expected %b", obs4, 5'b00100);
        end
    endtask

    task automatic test_reset_mid_grant;
        logic [4:0] exp;
        bus4.req1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs4 !== 5'b01110) begin
                errors++;
                $display("FAIL midrst_g1[%0d]: got %b expected %b", i, obs4, 5'b01110);
            end
        end
        // In GRANT1 with count 2 here.
        rst_n = 1'b0;
        tick();
        checks++;
        if (obs4 !== 5'b00000) begin
            errors++;
            $display("FAIL midrst_reset: got %b expected %b", obs4, 5'b00000);
        end
        rst_n     = 1'b1;
        bus4.req0 = 1'b1;
        bus4.req1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp = (i < 4) ? 5'b10010 : 5'b01111;
            checks++;
            if (obs4 !== exp) begin
                errors++;
                $display("FAIL midrst_window[%0d]: got %b expected %b", i, obs4, exp);
            end
        end
        bus4.req0 = 1'b0;
        bus4.req1 = 1'b0;
        tick();
    endtask

    task automatic test_alternate;
        logic [4:0] exp;
        bus1.req0 = 1'b1;
        bus1.req1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0)
                exp = 5'b10010;
            else if ((i % 2) == 1)
                exp = 5'b01111;
            else
                exp = 5'b10011;
            checks++;
            if (obs1 !== exp) begin
                errors++;
                $display("FAIL alternate_h1[%0d]: got %b expected %b", i, obs1, exp);
            end
        end
        bus1.req0 = 1'b0;
        bus1.req1 = 1'b0;
        tick();
        checks++;
        if (obs1 !== 5'b00000) begin
            errors++;
            $display("FAIL alternate_idle: got %b expected %b", obs1, 5'b00000);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bus4.req0 = 1'b0;
        bus4.req1 = 1'b0;
        bus1.req0 = 1'b0;
        bus1.req1 = 1'b0;

        test_reset();
        test_single();
        test_contention();
        test_release_handover();
        test_tie();
        test_reset_mid_grant();
        test_alternate();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
